stopwatch_control_core: RTL and testbench

Downstream consumer of the debounced one-cycle button pulses produced by the pushbutton conditioning stage. It runs a start/stop/lap/clear state machine and a BCD time counter (MM:SS.cc, centisecond resolution) advanced by an external 100 Hz tick enable. Its 24-bit BCD output feeds the 7-segment display driver directly, either live or lap-frozen.

---
 rtl/stopwatch_control_core.sv | 150 +++++++++++++++
 tb/tb_stopwatch_control_core.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_control_core.sv
// Stopwatch control: start/stop/lap/clear FSM driving an MM:SS.cc BCD counter
// advanced by a 100 Hz tick enable, with a lap-freeze register for the display.
module stopwatch_control_core #(
  parameter int unsigned MINUTES_MAX = 59
) (
  input  logic        clk_ms,
  input  logic        reset_n,
  input  logic        tick_10ms,
  input  logic        start_stop,
  input  logic        lap,
  input  logic        clear,
  output logic [23:0] disp_bcd,
  output logic        running,
  output logic        frozen,
  output logic        overflow,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RUN      = 3'd1;
  localparam logic [2:0] S_STOP     = 3'd2;
  localparam logic [2:0] S_LAP      = 3'd3;
  localparam logic [2:0] S_LAP_STOP = 3'd4;

  localparam logic [3:0] MAX_HI = 4'(MINUTES_MAX / 10);
  localparam logic [3:0] MAX_LO = 4'(MINUTES_MAX % 10);

  logic [2:0]  r_state;
  logic [23:0] r_count;
  logic [23:0] r_lap;
  logic        r_overflow;

  logic [2:0]  w_state_nxt;
  logic        w_lap_take;
  logic        w_counting;
  logic        w_inc;
  logic [23:0] w_count_inc;
  logic        w_wrap;

  logic [3:0] w_m_hi, w_m_lo, w_s_hi, w_s_lo, w_cs_hi, w_cs_lo;

  assign w_m_hi  = r_count[23:20];
  assign w_m_lo  = r_count[19:16];
  assign w_s_hi  = r_count[15:12];
  assign w_s_lo  = r_count[11:8];
  assign w_cs_hi = r_count[7:4];
  assign w_cs_lo = r_count[3:0];

  // Counting is decided by the state before this edge's transition.
  assign w_counting = (r_state == S_RUN) || (r_state == S_LAP);
  assign w_inc      = tick_10ms && w_counting;

  // Next-state decode; clear is handled in the register block and wins over both.
  always_comb begin
    w_state_nxt = r_state;
    w_lap_take  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_stop) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (start_stop) begin
          w_state_nxt = S_STOP;
        end else if (lap) begin
          w_state_nxt = S_LAP;
          w_lap_take  = 1'b1;
        end
      end
      S_STOP: begin
        if (start_stop) w_state_nxt = S_RUN;
      end
      S_LAP: begin
        if (start_stop) begin
          w_state_nxt = S_LAP_STOP;
        end else if (lap) begin
          w_lap_take  = 1'b1;
        end
      end
      S_LAP_STOP: begin
        if (start_stop) begin
          w_state_nxt = S_LAP;
        end else if (lap) begin
          w_state_nxt = S_STOP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // BCD ripple increment; the minutes field wraps at MINUTES_MAX:59.99.
  always_comb begin
    w_count_inc = r_count;
    w_wrap      = 1'b0;
    if (w_cs_lo != 4'd9) begin
      w_count_inc[3:0] = w_cs_lo + 4'd1;
    end else begin
      w_count_inc[3:0] = 4'd0;
      if (w_cs_hi != 4'd9) begin
        w_count_inc[7:4] = w_cs_hi + 4'd1;
      end else begin
        w_count_inc[7:4] = 4'd0;
        if (w_s_lo != 4'd9) begin
          w_count_inc[11:8] = w_s_lo + 4'd1;
        end else begin
          w_count_inc[11:8] = 4'd0;
          if (w_s_hi != 4'd5) begin
            w_count_inc[15:12] = w_s_hi + 4'd1;
          end else begin
            w_count_inc[15:12] = 4'd0;
            if ((w_m_hi == MAX_HI) && (w_m_lo == MAX_LO)) begin
              w_count_inc[23:16] = 8'h00;
              w_wrap             = 1'b1;
            end else if (w_m_lo != 4'd9) begin
              w_count_inc[19:16] = w_m_lo + 4'd1;
            end else begin
              w_count_inc[19:16] = 4'd0;
              w_count_inc[23:20] = w_m_hi + 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_ms) begin
    if (!reset_n || clear) begin
      r_state    <= S_IDLE;
      r_count    <= 24'h000000;
      r_lap      <= 24'h000000;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_inc) begin
        r_count <= w_count_inc;
        if (w_wrap) r_overflow <= 1'b1;
      end
      // Latch the pre-increment value even when a tick lands on the same edge.
      if (w_lap_take) r_lap <= r_count;
    end
  end

  assign running   = (r_state == S_RUN) || (r_state == S_LAP);
  assign frozen    = (r_state == S_LAP) || (r_state == S_LAP_STOP);
  assign disp_bcd  = frozen ? r_lap : r_count;
  assign overflow  = r_overflow;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_stopwatch_control_core.sv
// Bench for stopwatch_control_core: vector table, directed corner sequences and
// randomized pulses against a centisecond-integer reference model.
module tb_stopwatch_control_core;

  logic        clk_ms = 1'b0;
  logic        reset_n = 1'b1;
  logic        tick_10ms = 1'b0;
  logic        start_stop = 1'b0;
  logic        lap = 1'b0;
  logic        clear = 1'b0;

  logic [23:0] disp0, disp1;
  logic        run0, run1, frz0, frz1, ovf0, ovf1;
  logic [2:0]  dbg0, dbg1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_ms = ~clk_ms;

  stopwatch_control_core #(.MINUTES_MAX(59)) dut0 (
    .clk_ms(clk_ms), .reset_n(reset_n), .tick_10ms(tick_10ms),
    .start_stop(start_stop), .lap(lap), .clear(clear),
    .disp_bcd(disp0), .running(run0), .frozen(frz0), .overflow(ovf0),
    .dbg_state(dbg0)
  );

  stopwatch_control_core #(.MINUTES_MAX(1)) dut1 (
    .clk_ms(clk_ms), .reset_n(reset_n), .tick_10ms(tick_10ms),
    .start_stop(start_stop), .lap(lap), .clear(clear),
    .disp_bcd(disp1), .running(run1), .frozen(frz1), .overflow(ovf1),
    .dbg_state(dbg1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One clock: drive inputs on the falling edge, sample 1 time unit after the rising edge.
  task automatic cyc(input logic rst, input logic ss, input logic lp, input logic clr, input logic tk);
    @(negedge clk_ms);
    reset_n = rst; start_stop = ss; lap = lp; clear = clr; tick_10ms = tk;
    @(posedge clk_ms);
    #1;
    reset_n = 1'b1; start_stop = 1'b0; lap = 1'b0; clear = 1'b0; tick_10ms = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Reference model: time as an integer of centiseconds; running/frozen as two flags.
  int  m_cnt[2];
  int  m_lapv[2];
  bit  m_ovf[2];
  bit  m_run, m_frz;
  int  m_limit[2] = '{60 * 6000, 2 * 6000};

  function automatic logic [23:0] to_bcd(input int cs);
    int mins, secs, c;
    mins = cs / 6000;
    secs = (cs / 100) % 60;
    c    = cs % 100;
    return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  task automatic model_step(input bit rst, input bit ss, input bit lp, input bit clr, input bit tk);
    bit take;
    if (!rst || clr) begin
      for (int i = 0; i < 2; i++) begin m_cnt[i] = 0; m_lapv[i] = 0; m_ovf[i] = 0; end
      m_run = 0; m_frz = 0;
    end else begin
      take = !ss && lp && m_run;
      for (int i = 0; i < 2; i++) begin
        if (take) m_lapv[i] = m_cnt[i];
        if (tk && m_run) begin
          m_cnt[i]++;
          if (m_cnt[i] == m_limit[i]) begin m_cnt[i] = 0; m_ovf[i] = 1; end
        end
      end
      if (ss) m_run = !m_run;
      else if (lp) begin
        if (m_run) m_frz = 1;
        else if (m_frz) m_frz = 0;
      end
    end
  endtask

  typedef struct {
    logic        rst_n, ss, lp, clr, tk;
    logic [23:0] disp;
    logic        run, frz, ovf;
  } vec_t;

  vec_t tbl[19];

  initial begin
    // rst_n, ss, lp, clr, tk, disp, run, frz, ovf
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000001, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000002, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 24'h000002, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000002, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000004, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 24'h000004, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000004, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000005, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000005, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 24'h000005, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000006, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 24'h000007, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000000, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000001, 1'b1, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 24'h000000, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].rst_n, tbl[i].ss, tbl[i].lp, tbl[i].clr, tbl[i].tk);
      check($sformatf("vec%0d_disp", i), {8'h0, disp0}, {8'h0, tbl[i].disp});
      check($sformatf("vec%0d_flags", i), {29'h0, run0, frz0, ovf0},
            {29'h0, tbl[i].run, tbl[i].frz, tbl[i].ovf});
    end

    // Start, 150 ticks, stop; further ticks must not move the count.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick_n(150);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("stop_150_disp", {8'h0, disp0}, 32'h000150);
    check("stop_150_running", {31'h0, run0}, 32'h0);
    tick_n(10);
    check("stop_hold_disp", {8'h0, disp0}, 32'h000150);

    // Centisecond and seconds-to-minutes carries.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick_n(99);
    check("cnt_99", {8'h0, disp0}, 32'h000099);
    tick_n(1);
    check("carry_cs", {8'h0, disp0}, 32'h000100);
    tick_n(5899);
    check("cnt_5999", {8'h0, disp0}, 32'h005999);
    tick_n(1);
    check("carry_min", {8'h0, disp0}, 32'h010000);

    // Lap freeze and re-latch.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick_n(237);
    check("pre_lap", {8'h0, disp0}, 32'h000237);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick_n(20);
    check("lap_frozen_disp", {8'h0, disp0}, 32'h000237);
    check("lap_frozen_flag", {31'h0, frz0}, 32'h1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("lap_relatch", {8'h0, disp0}, 32'h000257);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("lapstop_release_disp", {8'h0, disp0}, 32'h000257);
    check("lapstop_release_flags", {30'h0, run0, frz0}, 32'h0);

    // Overflow on the MINUTES_MAX=1 instance; the default instance just carries on.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick_n(11999);
    check("small_max_time", {8'h0, disp1}, 32'h015999);
    tick_n(1);
    check("wrap_disp", {8'h0, disp1}, 32'h000000);
    check("wrap_ovf", {31'h0, ovf1}, 32'h1);
    check("big_no_wrap", {7'h0, ovf0, disp0}, 32'h020000);
    tick_n(3);
    check("wrap_keeps_counting", {7'h0, ovf1, disp1}, 32'h01000003);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("clear_ovf", {6'h0, ovf1, run1, disp1}, 32'h0);

    // Tick and lap on the same edge: lap holds pre-increment value.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick_n(9);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("tick_lap_latch", {8'h0, disp0}, 32'h000009);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("tick_lap_count", {8'h0, disp0}, 32'h000010);

    // Randomized pulses against the model, both instances.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 4000; n++) begin
      bit rst, ss, lp, clr, tk;
      rst = ($urandom_range(0, 299) != 0);
      ss  = ($urandom_range(0, 11) == 0);
      lp  = ($urandom_range(0, 9) == 0);
      clr = ($urandom_range(0, 79) == 0);
      tk  = ($urandom_range(0, 2) != 0);
      cyc(rst, ss, lp, clr, tk);
      model_step(rst, ss, lp, clr, tk);
      check($sformatf("rand%0d_dut0", n), {5'h0, disp0, run0, frz0, ovf0},
            {5'h0, (m_frz ? to_bcd(m_lapv[0]) : to_bcd(m_cnt[0])), m_run, m_frz, m_ovf[0]});
      check($sformatf("rand%0d_dut1", n), {5'h0, disp1, run1, frz1, ovf1},
            {5'h0, (m_frz ? to_bcd(m_lapv[1]) : to_bcd(m_cnt[1])), m_run, m_frz, m_ovf[1]});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
